// File: rtl/inst_queue_if.sv
// Fetch-to-decode instruction queue bus.
//
// Handshake: fetch may raise fifo_w_ena_1/2 at any time; a write is taken
// at the clock edge only when fifo_full was 0 in that cycle, otherwise the
// strobes are ignored (fetch must hold/replay). Decode sees head entries
// through fifo_r_valid_1/2 and tells the queue how many it consumed with
// fifo_r_num; the queue never pops more than it holds.
interface inst_queue_if;
    logic        fifo_w_ena_1;
    logic        fifo_w_ena_2;
    logic [31:0] fifo_w_pc_1;
    logic [31:0] fifo_w_pc_2;
    logic [31:0] fifo_w_inst_1;
    logic [31:0] fifo_w_inst_2;
    logic        fifo_full;
    logic [3:0]  fifo_count;
    logic [1:0]  fifo_r_num;
    logic        fifo_r_valid_1;
    logic        fifo_r_valid_2;
    logic [31:0] fifo_r_pc_1;
    logic [31:0] fifo_r_pc_2;
    logic [31:0] fifo_r_inst_1;
    logic [31:0] fifo_r_inst_2;

    // Fetch/decode side: drives write strobes/data and the consume count.
    modport master (
        output fifo_w_ena_1, fifo_w_ena_2,
        output fifo_w_pc_1, fifo_w_pc_2,
        output fifo_w_inst_1, fifo_w_inst_2,
        output fifo_r_num,
        input  fifo_full, fifo_count,
        input  fifo_r_valid_1, fifo_r_valid_2,
        input  fifo_r_pc_1, fifo_r_pc_2,
        input  fifo_r_inst_1, fifo_r_inst_2
    );

    // Queue side.
    modport slave (
        input  fifo_w_ena_1, fifo_w_ena_2,
        input  fifo_w_pc_1, fifo_w_pc_2,
        input  fifo_w_inst_1, fifo_w_inst_2,
        input  fifo_r_num,
        output fifo_full, fifo_count,
        output fifo_r_valid_1, fifo_r_valid_2,
        output fifo_r_pc_1, fifo_r_pc_2,
        output fifo_r_inst_1, fifo_r_inst_2
    );
endinterface

// File: rtl/inst_queue.sv
// 8-entry, 2-wide-in / 2-wide-out instruction queue between fetch and decode.
// Writes are compacted at the tail, reads expose head and head+1
// combinationally from registered state; invalid read slots show a NOP (0).
module inst_queue (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    inst_queue_if.slave  q
);
    // Storage (no reset: pointers and count alone define what is valid)
    logic [31:0] mem_pc_q   [8];
    logic [31:0] mem_pc_d   [8];
    logic [31:0] mem_inst_q [8];
    logic [31:0] mem_inst_d [8];

    logic [2:0]  rptr_q, rptr_d;
    logic [2:0]  wptr_q, wptr_d;
    logic [3:0]  count_q, count_d;

    logic        full;
    logic        wr_allow;
    logic [1:0]  push_n;
    logic [1:0]  r_num_clamped;
    logic [1:0]  pop_n;
    logic [2:0]  wptr_p1;
    logic [2:0]  rptr_p1;

    // Full threshold leaves room for one two-wide push; registered count only.
    always_comb begin
        full     = (count_q >= 4'd7);
        wr_allow = !full && !flush;
        wptr_p1  = wptr_q + 3'd1;
        rptr_p1  = rptr_q + 3'd1;
    end

    // Push and pop amounts: strobes ignored when full, pops bounded by count.
    always_comb begin
        push_n = 2'd0;
        if (!full) begin
            push_n = {1'b0, q.fifo_w_ena_1} + {1'b0, q.fifo_w_ena_2};
        end
        r_num_clamped = (q.fifo_r_num == 2'd3) ? 2'd2 : q.fifo_r_num;
        if ({2'b00, r_num_clamped} > count_q) begin
            // Only reachable with count 0 or 1, so the low bits are exact.
            pop_n = count_q[1:0];
        end else begin
            pop_n = r_num_clamped;
        end
    end

    // Storage update: compact accepted writes at wptr; flush discards them.
    always_comb begin
        mem_pc_d   = mem_pc_q;
        mem_inst_d = mem_inst_q;
        if (wr_allow) begin
            if (q.fifo_w_ena_1) begin
                mem_pc_d[wptr_q]   = q.fifo_w_pc_1;
                mem_inst_d[wptr_q] = q.fifo_w_inst_1;
                if (q.fifo_w_ena_2) begin
                    mem_pc_d[wptr_p1]   = q.fifo_w_pc_2;
                    mem_inst_d[wptr_p1] = q.fifo_w_inst_2;
                end
            end else if (q.fifo_w_ena_2) begin
                mem_pc_d[wptr_q]   = q.fifo_w_pc_2;
                mem_inst_d[wptr_q] = q.fifo_w_inst_2;
            end
        end
    end

    // Pointer/count next state; flush empties the queue ahead of push/pop.
    always_comb begin
        rptr_d  = rptr_q + {1'b0, pop_n};
        wptr_d  = wptr_q + {1'b0, push_n};
        count_d = count_q + {2'b00, push_n} - {2'b00, pop_n};
        if (flush) begin
            rptr_d  = 3'd0;
            wptr_d  = 3'd0;
            count_d = 4'd0;
        end
    end

    // Control state registers; reset beats flush, push and pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q  <= 3'd0;
            wptr_q  <= 3'd0;
            count_q <= 4'd0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Storage registers.
    always_ff @(posedge clk) begin
        mem_pc_q   <= mem_pc_d;
        mem_inst_q <= mem_inst_d;
    end

    // Read ports: head and head+1, zeroed (NOP) when not valid.
    always_comb begin
        q.fifo_full      = full;
        q.fifo_count     = count_q;
        q.fifo_r_valid_1 = (count_q >= 4'd1);
        q.fifo_r_valid_2 = (count_q >= 4'd2);
        q.fifo_r_pc_1    = 32'h0;
        q.fifo_r_inst_1  = 32'h0;
        q.fifo_r_pc_2    = 32'h0;
        q.fifo_r_inst_2  = 32'h0;
        if (q.fifo_r_valid_1) begin
            q.fifo_r_pc_1   = mem_pc_q[rptr_q];
            q.fifo_r_inst_1 = mem_inst_q[rptr_q];
        end
        if (q.fifo_r_valid_2) begin
            q.fifo_r_pc_2   = mem_pc_q[rptr_p1];
            q.fifo_r_inst_2 = mem_inst_q[rptr_p1];
        end
    end
endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; no other clock or asynchronous input is permitted.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 flush  in  1  pipeline redirect; empties the queue.
REQ-005 fifo_w_ena_1, fifo_w_ena_2  in  1 each  fetch write strobes, slot 1 older than slot 2.
REQ-006 fifo_w_pc_1, fifo_w_pc_2  in  32 each  PC of the fetched instruction.
REQ-007 fifo_w_inst_1, fifo_w_inst_2  in  32 each  fetched instruction word.
REQ-008 fifo_full  out  1  fewer than 2 free entries; fetch stalls.
REQ-009 fifo_count  out  4  valid entries held, 0..8.
REQ-010 fifo_r_num  in  2  entries consumed by decode this cycle, 0..2; value 3 is treated as 2.
REQ-011 fifo_r_valid_1, fifo_r_valid_2  out  1 each  head and head+1 entries are valid.
REQ-012 fifo_r_pc_1, fifo_r_pc_2, fifo_r_inst_1, fifo_r_inst_2  out  32 each  head and head+1 PC and instruction, feeding the two decode lanes.

Function
REQ-013 Storage SHALL be 8 entries of {pc[31:0], inst[31:0]}, with 3-bit read and write pointers that wrap modulo 8 and a 4-bit count.
REQ-014 Read outputs SHALL be combinational from registered storage and pointers, so read latency is 0 cycles from entry state.
REQ-015 A write becomes visible on the read ports in the cycle after the write edge.
REQ-016 fifo_r_valid_1 SHALL equal (count >= 1) and fifo_r_valid_2 SHALL equal (count >= 2).
REQ-017 When a read slot is invalid, its inst SHALL be driven to 32'h0 (NOP) and its pc to 32'h0.
REQ-018 fifo_full SHALL equal (count >= 7), computed from registered count only.
REQ-019 A write SHALL be accepted only when fifo_full is 0; while fifo_full is 1, the write strobes are ignored and nothing is written.
REQ-020 Accepted writes SHALL be compacted at the tail:
 - both strobes set: slot 1 is written at wptr and slot 2 at wptr+1.
 - only one strobe set: that slot is written at wptr.
 - wptr advances by the number of strobes set.
REQ-021 The effective pop is pop_n = min(fifo_r_num clamped to 2, count), so over-popping never underflows; rptr advances by pop_n.
REQ-022 Simultaneous push and pop in one cycle SHALL both take effect, with count_next = count + push_n - pop_n.
REQ-023 Pop uses the pre-edge head, so data written this cycle cannot be popped this cycle.
REQ-024 flush SHALL take priority over push and pop: on the next edge rptr, wptr and count go to 0; write data presented in the same cycle is discarded.
REQ-025 Storage contents need not be cleared by flush or reset; only pointers and count are cleared.
REQ-026 count SHALL never exceed 8.
REQ-027 By construction (REQ-018, REQ-019), a write can never overwrite an unread entry.

Reset
REQ-028 On rst=1 at a clock edge, rptr, wptr and count SHALL become 0.
REQ-029 After that edge: fifo_full=0, fifo_count=0, both valid outputs 0, read inst/pc outputs 0.
REQ-030 rst SHALL take priority over flush, push and pop, including when asserted mid-stream with a nonempty queue.

Verification
REQ-031 Reset, then push pc 0x100/0x104 with inst 0x24010001/0x24020002 in one cycle -> next cycle: count=2, valid_1=valid_2=1, r_pc_1=0x100, r_inst_2=0x24020002.
REQ-032 Fill with 4 two-wide pushes and no pops -> after the 4th edge count=8 and fifo_full=1, and fifo_full was already 1 after the 7th entry would be reached (count 6 -> push 2 -> 8 permitted; a further push with full=1 -> count stays 8, no data change).
REQ-033 count=1 holding pc 0x200, fifo_r_num=2 -> pop_n=1, count=0 next cycle; valid_1=0 and r_inst_1=0.
REQ-034 Only fifo_w_ena_2 set (pc 0x300) on an empty queue -> next cycle r_pc_1=0x300, count=1 (compaction).
REQ-035 count=3, push 2 and pop 2 in the same cycle with wptr=7 -> count=3, wptr wraps to 1, FIFO order preserved across the wrap.
REQ-036 count=5, flush=1 together with a push and fifo_r_num=1 -> next cycle count=0 and both valid outputs 0.
REQ-037 count=5, rst=1 together with flush and push -> next cycle count=0 and full=0.
